// File: rtl/game_ctrl_bank.sv
// Keypad menu FSM (MENU/HELP/SELECT/PLAY) editing a cursor-addressed bank of modulo counters, with a stretched buzzer alarm on wrap.
// Latency: a press acts on the first clk edge that sees it; all outputs are registered, so they change on that edge (1 cycle).
// Backpressure: none; each press is a single-shot event, and lower-priority simultaneous presses are dropped, not queued.
// Optional: define GAME_CTRL_TIMEOUT_EN to leave PLAY for MENU after TIMEOUT_CYC cycles without a key press.
module game_ctrl_bank #(
    parameter int NUM_CH      = 10,
    parameter int DIGIT_W     = 4,
    parameter int MOD         = 10,
    parameter int INIT_VAL    = 1,
    parameter int ALARM_CYC   = 25000000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   key,
    output logic [1:0]                    state,
    output logic [$clog2(NUM_CH+1)-1:0]   active_cnt,
    output logic [$clog2(NUM_CH)-1:0]     cursor,
    output logic [NUM_CH*DIGIT_W-1:0]     status,
    output logic                          alarm
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int CUR_W = $clog2(NUM_CH);
    localparam int ALM_W = $clog2(ALARM_CYC + 1);

    localparam logic [DIGIT_W-1:0] DIG_MAX  = DIGIT_W'(MOD - 1);
    localparam logic [DIGIT_W-1:0] DIG_INIT = DIGIT_W'(INIT_VAL);

    // Key positions on the scanner bus
    localparam int K_HELP  = 15;
    localparam int K_NEXT  = 14;
    localparam int K_BACK  = 13;
    localparam int K_EXIT  = 12;
    localparam int K_COUNT = 11;
    localparam int K_LEFT  = 7;
    localparam int K_DOWN  = 6;
    localparam int K_RIGHT = 5;
    localparam int K_UP    = 2;

    // Reject parameter sets the counter and cursor arithmetic cannot represent
    if (NUM_CH < 2 || NUM_CH > 16 || MOD < 2 || MOD > (1 << DIGIT_W) ||
        INIT_VAL < 0 || INIT_VAL >= MOD || ALARM_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("game_ctrl_bank: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_MENU   = 2'b00,
        S_HELP   = 2'b01,
        S_SELECT = 2'b10,
        S_PLAY   = 2'b11
    } state_t;

    typedef enum logic [3:0] {
        A_NONE,
        A_TO_HELP,
        A_TO_SELECT,
        A_TO_MENU,
        A_COUNT,
        A_TO_PLAY,
        A_LEFT,
        A_RIGHT,
        A_UP,
        A_DOWN
    } act_t;

    state_t               state_q;
    logic [CNT_W-1:0]     active_cnt_q;
    logic [CUR_W-1:0]     cursor_q;
    logic [DIGIT_W-1:0]   ch [NUM_CH];
    logic [ALM_W-1:0]     alarm_cnt;
    logic                 alarm_q;

    logic [15:0]          key_q;
    logic [15:0]          press;
    act_t                 act;
    logic [DIGIT_W-1:0]   cur_val;
    logic [DIGIT_W-1:0]   ch_next;
    logic                 wrap;
    logic [CUR_W-1:0]     cursor_last;
    logic                 timeout;

    assign press       = key & ~key_q;
    assign cursor_last = CUR_W'(active_cnt_q - CNT_W'(1));

    // Keys with no action here (confirm and the spare positions) only matter to the idle timer
    logic unused_keys;
    assign unused_keys = ^{press[10:8], press[4:3], press[1:0]};

    // Key history for rising-edge detection; a held key yields a single press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
        end else begin
            key_q <= key;
        end
    end

    // Pick the single highest-priority event that is meaningful in the current state
    always_comb begin
        act = A_NONE;
        case (state_q)
            S_MENU: begin
                if      (press[K_HELP]) act = A_TO_HELP;
                else if (press[K_NEXT]) act = A_TO_SELECT;
            end
            S_HELP: begin
                if      (press[K_NEXT]) act = A_TO_SELECT;
                else if (press[K_BACK]) act = A_TO_MENU;
            end
            S_SELECT: begin
                if      (press[K_EXIT])  act = A_TO_MENU;
                else if (press[K_NEXT])  act = A_TO_PLAY;
                else if (press[K_COUNT]) act = A_COUNT;
            end
            S_PLAY: begin
                if      (press[K_EXIT])  act = A_TO_MENU;
                else if (press[K_LEFT])  act = A_LEFT;
                else if (press[K_RIGHT]) act = A_RIGHT;
                else if (press[K_UP])    act = A_UP;
                else if (press[K_DOWN])  act = A_DOWN;
            end
            default: act = A_NONE;
        endcase
    end

    // Next value of the channel under the cursor and whether that edit wraps
    always_comb begin
        cur_val = ch[cursor_q];
        ch_next = cur_val;
        wrap    = 1'b0;
        if (act == A_UP) begin
            if (cur_val == DIG_MAX) begin
                ch_next = '0;
                wrap    = 1'b1;
            end else begin
                ch_next = cur_val + DIGIT_W'(1);
            end
        end else if (act == A_DOWN) begin
            if (cur_val == '0) begin
                ch_next = DIG_MAX;
                wrap    = 1'b1;
            end else begin
                ch_next = cur_val - DIGIT_W'(1);
            end
        end
    end

`ifdef GAME_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Timeout fires on the cycle that would complete TIMEOUT_CYC press-free PLAY cycles
    assign timeout = (state_q == S_PLAY) && (press == '0) &&
                     (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Idle timer: runs only in PLAY, restarts on any press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state_q != S_PLAY || press != '0 || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Menu FSM, channel bank, cursor and alarm stretcher
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_MENU;
            active_cnt_q <= CNT_W'(1);
            cursor_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch[i] <= DIG_INIT;
            end
            alarm_cnt    <= '0;
            alarm_q      <= 1'b0;
        end else begin
            // Default alarm behaviour is to count down; wraps and exits override it below
            if (alarm_cnt != '0) begin
                alarm_cnt <= alarm_cnt - ALM_W'(1);
                alarm_q   <= (alarm_cnt != ALM_W'(1));
            end

            if (timeout) begin
                state_q   <= S_MENU;
                alarm_cnt <= '0;
                alarm_q   <= 1'b0;
            end else begin
                case (act)
                    A_TO_HELP:   state_q <= S_HELP;
                    A_TO_SELECT: state_q <= S_SELECT;
                    A_TO_MENU: begin
                        state_q   <= S_MENU;
                        alarm_cnt <= '0;
                        alarm_q   <= 1'b0;
                    end
                    A_COUNT: begin
                        if (active_cnt_q == CNT_W'(NUM_CH)) begin
                            active_cnt_q <= CNT_W'(1);
                        end else begin
                            active_cnt_q <= active_cnt_q + CNT_W'(1);
                        end
                    end
                    A_TO_PLAY: begin
                        state_q  <= S_PLAY;
                        cursor_q <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            ch[i] <= DIG_INIT;
                        end
                    end
                    A_LEFT: begin
                        cursor_q <= (cursor_q == '0) ? cursor_last : cursor_q - CUR_W'(1);
                    end
                    A_RIGHT: begin
                        cursor_q <= (cursor_q == cursor_last) ? '0 : cursor_q + CUR_W'(1);
                    end
                    A_UP, A_DOWN: begin
                        ch[cursor_q] <= ch_next;
                        if (wrap) begin
                            alarm_cnt <= ALM_W'(ALARM_CYC);
                            alarm_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state      = state_q;
    assign active_cnt = active_cnt_q;
    assign cursor     = cursor_q;
    assign alarm      = alarm_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_status
        assign status[g*DIGIT_W +: DIGIT_W] = ch[g];
    end

endmodule

// File: tb/tb_game_ctrl_bank.sv
// Directed bench for game_ctrl_bank: expectations are queued when a step is driven and compared when the DUT settles.
module tb_game_ctrl_bank;

    localparam int NUM_CH      = 10;
    localparam int DIGIT_W     = 4;
    localparam int MOD         = 10;
    localparam int INIT_VAL    = 1;
    localparam int ALARM_CYC   = 8;
    localparam int TIMEOUT_CYC = 20;

`ifdef GAME_CTRL_TIMEOUT_EN
    localparam int HOLD_CYC = 15;
    localparam int IDLE_END_ST = 0;
`else
    localparam int HOLD_CYC = 100;
    localparam int IDLE_END_ST = 3;
`endif

    localparam logic [15:0] K2  = 16'h0004;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K7  = 16'h0080;
    localparam logic [15:0] K10 = 16'h0400;
    localparam logic [15:0] K11 = 16'h0800;
    localparam logic [15:0] K12 = 16'h1000;
    localparam logic [15:0] K13 = 16'h2000;
    localparam logic [15:0] K14 = 16'h4000;
    localparam logic [15:0] K15 = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key;
    logic [1:0]  state;
    logic [3:0]  active_cnt;
    logic [3:0]  cursor;
    logic [39:0] status;
    logic        alarm;

    always #5 clk = ~clk;

    game_ctrl_bank #(
        .NUM_CH(NUM_CH), .DIGIT_W(DIGIT_W), .MOD(MOD), .INIT_VAL(INIT_VAL),
        .ALARM_CYC(ALARM_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .state(state), .active_cnt(active_cnt),
        .cursor(cursor), .status(status), .alarm(alarm)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  cnt;
        logic [3:0]  cur;
        logic [39:0] stat;
        logic        alm;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Hand-maintained expectation of the DUT's visible state
    int    m_st, m_cnt, m_cur;
    int    m_ch [NUM_CH];
    logic  m_alarm;
    logic  hist [0:19];
    int    n_hi;

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 2'(m_st);
        o.cnt  = 4'(m_cnt);
        o.cur  = 4'(m_cur);
        o.stat = '0;
        for (int i = 0; i < NUM_CH; i++) o.stat[i*4 +: 4] = 4'(m_ch[i]);
        o.alm  = m_alarm;
        return o;
    endfunction

    task automatic push_exp(input string tag);
        exp_q.push_back(model_obs());
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        obs_t  e;
        obs_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = '{st: state, cnt: active_cnt, cur: cursor, stat: status, alm: alarm};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed st=%0d cnt=%0d cur=%0d status=%h alarm=%0b expected st=%0d cnt=%0d cur=%0d status=%h alarm=%0b",
                   t, o.st, o.cnt, o.cur, o.stat, o.alm, e.st, e.cnt, e.cur, e.stat, e.alm);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One press: key high for a single edge, then released for one edge so the next press is a fresh edge
    task automatic tap(input logic [15:0] m, input string tag);
        push_exp(tag);
        @(negedge clk) key = m;
        @(negedge clk) key = '0;
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        m_st = 0; m_cnt = 1; m_cur = 0; m_alarm = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = INIT_VAL;

        rst = 1'b1;
        key = '0;
        #1 rst = 1'b0;
        push_exp("reset_values");
        #2 check_pop();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        m_st = 1; tap(K15, "menu_to_help");
        m_st = 0; tap(K13, "help_back");
        m_st = 2; tap(K14, "menu_to_select");
        for (int i = 0; i < 3; i++) begin
            m_cnt = m_cnt + 1;
            tap(K11, "count_step");
        end
        m_st = 3; tap(K14, "select_to_play");

        m_cur = 3; tap(K7, "left_wrap");
        m_cur = 0; tap(K5, "right_wrap");
        for (int i = 1; i <= 4; i++) begin
            m_cur = i % 4;
            tap(K5, "right_cycle");
        end
        m_cur = 3; tap(K7 | K5, "left_beats_right");
        m_cur = 0; tap(K5, "right_back");

        for (int i = 0; i < 8; i++) begin
            m_ch[0] = m_ch[0] + 1;
            tap(K2, "up_no_wrap");
        end

        // Ninth up on channel 0 wraps 9 -> 0: alarm must be high for exactly ALARM_CYC cycles
        @(negedge clk) key = K2;
        n_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            key = '0;
            hist[i] = alarm;
            if (alarm) n_hi++;
        end
        chk("alarm_len", n_hi, ALARM_CYC);
        chk("alarm_first", int'(hist[0]), 1);
        chk("alarm_last", int'(hist[ALARM_CYC-1]), 1);
        chk("alarm_drop", int'(hist[ALARM_CYC]), 0);
        m_ch[0] = 0;
        push_exp("up_wrap_value");
        check_pop();

        // Wrap down at cycle 0, wrap up again at cycle 5: alarm must run through cycle 5+ALARM_CYC-1
        @(negedge clk) key = K6;
        n_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hist[i] = alarm;
            if (alarm) n_hi++;
            key = (i == 4) ? K2 : 16'h0000;
        end
        chk("alarm_ext_len", n_hi, 5 + ALARM_CYC);
        chk("alarm_ext_last", int'(hist[5 + ALARM_CYC - 1]), 1);
        chk("alarm_ext_drop", int'(hist[5 + ALARM_CYC]), 0);
        push_exp("double_wrap_value");
        check_pop();

        m_cur = 1; tap(K5, "cursor_ch1");
        m_ch[1] = 0; tap(K6, "down_no_wrap");
        m_ch[1] = 9; m_alarm = 1'b1; tap(K6, "down_wrap");
        m_st = 0; m_alarm = 1'b0; tap(K12 | K2, "exit_beats_up");
        tap(K2, "menu_ignores_up");

        m_st = 2; tap(K14, "reselect");
        m_st = 3; m_cur = 0;
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = INIT_VAL;
        tap(K14, "replay_reload");

        // A held key must produce exactly one increment
        @(negedge clk) key = K2;
        repeat (HOLD_CYC) @(negedge clk);
        key = '0;
        @(negedge clk);
        m_ch[0] = 2;
        push_exp("held_key_once");
        check_pop();

        m_ch[0] = 1; tap(K6, "down_to_1");
        m_ch[0] = 0; tap(K6, "down_to_0");
        m_ch[0] = 9; m_alarm = 1'b1; tap(K6, "down_wrap_pre_reset");

        // Asynchronous reset between clock edges, mid-alarm and mid-PLAY
        @(negedge clk);
        #2 rst = 1'b0;
        m_st = 0; m_cnt = 1; m_cur = 0; m_alarm = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = INIT_VAL;
        push_exp("async_reset");
        #1 check_pop();
        @(negedge clk) rst = 1'b1;

        // Idle behaviour in PLAY
        m_st = 2; tap(K14, "idle_select");
        m_st = 3; tap(K14, "idle_play");
        repeat (18) @(negedge clk);
        chk("idle_19_still_play", int'(state), 3);
        @(negedge clk);
        chk("idle_20_state", int'(state), IDLE_END_ST);

        m_st = 0; tap(K12, "idle_exit");
        m_st = 2; tap(K14, "idle_select2");
        m_st = 3; tap(K14, "idle_play2");
        repeat (17) @(negedge clk);
        key = K10;
        @(negedge clk) key = '0;
        repeat (10) @(negedge clk);
        chk("press_at_19_keeps_play", int'(state), 3);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/game_ctrl_bank.md
Name: game_ctrl_bank

Overview:
- Parametrised successor to the keypad game controller.
- Takes raw key levels from the matrix-key scanner, edge-detects them and runs the menu FSM (MENU/HELP/SELECT/PLAY).
- Owns an NUM_CH-channel bank of DIGIT_W-bit modulo-MOD counters that the player edits with a cursor.
- Drives an alarm output, stretched to ALARM_CYC cycles, whenever an edited channel wraps; this output feeds the buzzer.

Parameters:
- NUM_CH, 10, number of counter channels (2..16)
- DIGIT_W, 4, bits per channel
- MOD, 10, counter modulus (2..2**DIGIT_W)
- INIT_VAL, 1, value loaded into every channel at reset and on PLAY entry (< MOD)
- ALARM_CYC, 25000000, alarm pulse length in clk cycles
- TIMEOUT_CYC, 500000000, idle timeout (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key  in  16  key levels from matrix scanner, 1 = pressed
- state  out  2  00 MENU, 01 HELP, 10 SELECT, 11 PLAY
- active_cnt  out  $clog2(NUM_CH+1)  active channel count, 1..NUM_CH
- cursor  out  $clog2(NUM_CH)  selected channel index
- status  out  NUM_CH*DIGIT_W  channel i at bits [i*DIGIT_W +: DIGIT_W]
- alarm  out  1  buzzer enable

Behaviour:
- Reset (rst low, async) values:
  - state = MENU, active_cnt = 1, cursor = 0
  - every channel = INIT_VAL, alarm = 0
  - all internal counters and key-history registers = 0
- Key events:
  - press[k] = key[k] & ~key_q[k]; key_q is registered each cycle.
  - One event per press, acted on in the same cycle press is high. Outputs update on the following clk edge (1-cycle latency).
  - Key held: no repeat.
- Key map:
  - 15 help, 14 next, 13 back, 12 exit, 11 count
  - 2 up, 6 down, 7 left, 5 right
  - 10 confirm (no action in this block)
- FSM transitions:
  - MENU: 15 -> HELP; 14 -> SELECT.
  - HELP: 13 -> MENU; 14 -> SELECT.
  - SELECT:
    - 11 -> active_cnt+1, wrapping NUM_CH -> 1.
    - 14 -> PLAY: all channels reloaded to INIT_VAL, cursor = 0.
    - 12 -> MENU.
  - PLAY: 12 -> MENU; alarm cleared and its counter zeroed.
  - All other keys in a state are ignored.
- Simultaneous presses, priority high to low:
  - 12 > 15 > 14 > 13 > 11 > cursor keys (7, 5) > edit keys (2, 6).
  - Only the highest-priority applicable event acts that cycle; the rest are discarded, not queued.
- PLAY editing (cursor < active_cnt always):
  - 7: cursor-1, wrapping 0 -> active_cnt-1.
  - 5: cursor+1, wrapping active_cnt-1 -> 0.
  - 2: channel[cursor]+1. MOD-1 -> 0 is a wrap event.
  - 6: channel[cursor]-1. 0 -> MOD-1 is a wrap event.
  - Channels >= active_cnt hold their value and are never edited.
- Alarm:
  - A wrap event loads the alarm counter with ALARM_CYC and sets alarm = 1.
  - The counter decrements each cycle; alarm drops when it reaches 0.
  - A wrap during an active alarm reloads the counter, giving a full ALARM_CYC from the new event.
- status changes only on PLAY-entry reload or an edit; it is held in all other states.
- Reset asserted mid-alarm or mid-PLAY: immediate return to reset values with no glitch on alarm beyond the async clear.

Optional Feature:
- GAME_CTRL_TIMEOUT_EN defined: in PLAY, an idle counter counts clk cycles since the last press of any key. On reaching TIMEOUT_CYC, state goes to MENU, alarm is cleared and the counter is cleared. Any press resets the counter; it is also zeroed outside PLAY.
- Undefined: no idle counter, PLAY persists indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- Reset, then key[14] pulse, then 3x key[11], then key[14] -> state 10 then 11, active_cnt = 4, cursor = 0, status = 0x1111111111.
- In PLAY with active_cnt = 4: key[7] once -> cursor = 3; key[5] once -> cursor = 0; key[5] 4x -> cursor = 0.
- In PLAY, key[2] 9x on channel 0 -> channel 0 = 0 and alarm high for exactly ALARM_CYC cycles (ALARM_CYC = 8 in bench); a second wrap at cycle 5 extends alarm to cycle 5+8.
- key[6] on a channel holding 0 -> MOD-1 (9), alarm asserted; key[12] and key[2] pressed together -> state MENU, status unchanged, alarm = 0.
- key[2] held high for 100 cycles -> exactly one increment; rst pulled low mid-alarm -> alarm = 0, state = 00 and status = INIT_VAL pattern with no clk edge required.
- With GAME_CTRL_TIMEOUT_EN and TIMEOUT_CYC = 20: idle in PLAY for 20 cycles -> state 00; a press at cycle 19 -> PLAY persists.
